uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 125 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmitter that pops bytes from a standard (non-FWFT) FIFO and
// shifts them out LSB first, with baud timing from an internal clock divider.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               txEnable,
  input  logic               fifoEmpty,
  input  logic [7:0]         fifoDout,
  output logic               readEn,
  output logic               txData,
  output logic               busy,
  output logic [COUNT_W-1:0] bytesSent
);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop} state_e;

  localparam logic [12:0] BaudLast = 13'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  StopLast = 3'(STOP_BITS - 1);

  state_e               state_q, state_d;
  logic [12:0]          baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 baud_done;

  assign baud_done = (baud_q == BaudLast);
  assign readEn    = (state_q == StIdle) & txEnable & ~fifoEmpty & ~rst;
  assign busy      = (state_q != StIdle);
  assign txData    = tx_q;
  assign bytesSent = count_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (readEn) state_d = StLoad;
      end
      // fifoDout is valid here, one cycle after the pop strobe
      StLoad: begin
        shift_d = fifoDout;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = StStart;
      end
      StStart: begin
        if (baud_done) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 13'd1;
        end
      end
      // bit_q is the index of the data bit currently on the line
      StData: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            bit_d   = '0;
            state_d = StStop;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 13'd1;
        end
      end
      StStop: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == StopLast) begin
            bit_d   = '0;
            count_d = count_q + 1'b1;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 13'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  // Reset abandons any frame in flight and returns the line high immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: a FIFO model feeds the DUT, pushes record
// expected bytes, and a UART line monitor decodes frames and compares in order.
module tb_uart_tx_serializer;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txEnable = 1'b0;
  logic       fifoEmpty = 1'b1;
  logic [7:0] fifoDout = 8'h00;
  logic       readEn, txData, busy;
  logic [3:0] bytesSent;

  logic       fifoEmpty2 = 1'b1;
  logic [7:0] fifoDout2 = 8'hFF;
  logic       readEn2, txData2, busy2;
  logic [7:0] bytesSent2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] exp_q[$];
  int         start_q[$];

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(1), .COUNT_W(4)) dut (
    .clk(clk), .rst(rst), .txEnable(txEnable), .fifoEmpty(fifoEmpty), .fifoDout(fifoDout),
    .readEn(readEn), .txData(txData), .busy(busy), .bytesSent(bytesSent)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(2), .COUNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .txEnable(1'b1), .fifoEmpty(fifoEmpty2), .fifoDout(fifoDout2),
    .readEn(readEn2), .txData(txData2), .busy(busy2), .bytesSent(bytesSent2)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (readEn) rd_cnt <= rd_cnt + 1;
  end

  // Non-FWFT FIFO: data appears the cycle after the pop; pushes land a cycle later
  always @(posedge clk) begin
    if (readEn && fifo_q.size() > 0) fifoDout <= fifo_q.pop_front();
    while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    fifoEmpty <= (fifo_q.size() == 0);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    pend_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_fall(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txData !== 1'b0 && n < 200);
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL %s got=timeout expected=start_bit", nm);
    end
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(!busy && !readEn && (fifoEmpty || !txEnable) && pend_q.size() == 0)
               && n < maxc);
    if (n >= maxc) begin
      checks++;
      failures++;
      $display("FAIL %s got=timeout expected=idle", nm);
    end
  endtask

  // Line monitor: samples mid-bit, abandons the frame if reset is seen
  initial begin
    logic       prev;
    logic       ab;
    logic [9:0] bits;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev === 1'b1 && txData === 1'b0) begin
        start_q.push_back(cyc);
        ab = 1'b0;
        bits = '0;
        for (int j = 0; j < 10; j++) begin
          for (int k = 0; k < ((j == 0) ? 1 : C); k++) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
          end
          if (ab) break;
          bits[j] = txData;
        end
        if (ab) begin
          if (exp_q.size() > 0) e = exp_q.pop_front();
        end else if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame got=%02h expected=none", bits[8:1]);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", 32'(bits[8:1]), 32'(e));
          check("frame_start_stop", 32'({bits[9], bits[0]}), 32'h2);
        end
      end
      prev = txData;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int bad;
    repeat (2) step();
    @(negedge clk);
    check("rst_txData", 32'(txData), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_bytesSent", 32'(bytesSent), 32'h0);
    check("rst_readEn", 32'(readEn), 32'h0);
    check("rst_txData2", 32'(txData2), 32'h1);
    step();
    rst = 1'b0;
    txEnable = 1'b1;

    // Single byte 0x55
    step();
    push(8'h55);
    bad = 1;
    for (int i = 0; i < 10 && bad == 1; i++) begin
      @(negedge clk);
      if (readEn === 1'b1) bad = 0;
    end
    check("t1_readEn_seen", 32'(bad), 32'h0);
    @(negedge clk);
    check("t1_readEn_one_cycle", 32'(readEn), 32'h0);
    check("t1_load_line_high", 32'(txData), 32'h1);
    @(negedge clk);
    check("t1_start_low", 32'(txData), 32'h0);
    repeat (39) @(negedge clk);
    check("t1_busy_39", 32'(busy), 32'h1);
    @(negedge clk);
    check("t1_busy_40", 32'(busy), 32'h0);
    check("t1_bytesSent", 32'(bytesSent), 32'h1);

    // Back-to-back frames
    step();
    start_q.delete();
    r0 = rd_cnt;
    push(8'h48); push(8'h42); push(8'h0D); push(8'h0A);
    wait_idle("t2_idle", 400);
    check("t2_frames", 32'(start_q.size()), 32'h4);
    for (int i = 0; i < 3 && i + 1 < start_q.size(); i++)
      check("t2_start_gap", 32'(start_q[i+1] - start_q[i]), 32'd42);
    check("t2_readEn_pulses", 32'(rd_cnt - r0), 32'h4);
    check("t2_bytesSent", 32'(bytesSent), 32'h5);
    check("t2_idle_line", 32'(txData), 32'h1);

    // txEnable gate during d3
    step();
    r0 = rd_cnt;
    push(8'hA3); push(8'h11); push(8'h22);
    wait_fall("t3_fall");
    repeat (17) @(negedge clk);
    step();
    txEnable = 1'b0;
    wait_idle("t3_idle", 200);
    repeat (10) step();
    @(negedge clk);
    check("t3_single_pop", 32'(rd_cnt - r0), 32'h1);
    check("t3_busy_gated", 32'(busy), 32'h0);
    check("t3_line_high", 32'(txData), 32'h1);
    check("t3_bytesSent", 32'(bytesSent), 32'h6);
    step();
    txEnable = 1'b1;
    @(negedge clk);
    check("t3_readEn_resume", 32'(readEn), 32'h1);
    @(negedge clk);
    check("t3_load_line", 32'(txData), 32'h1);
    @(negedge clk);
    check("t3_start_low", 32'(txData), 32'h0);
    wait_idle("t3_idle2", 400);
    check("t3_bytesSent2", 32'(bytesSent), 32'h8);
    check("t3_pops", 32'(rd_cnt - r0), 32'h3);

    // Reset during d5
    step();
    push(8'h3C); push(8'h5A);
    wait_fall("t4_fall");
    repeat (25) @(negedge clk);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("t4_rst_line", 32'(txData), 32'h1);
    check("t4_rst_busy", 32'(busy), 32'h0);
    check("t4_rst_count", 32'(bytesSent), 32'h0);
    check("t4_rst_readEn", 32'(readEn), 32'h0);
    check("t4_rst_fifo_pending", 32'(fifoEmpty), 32'h0);
    step();
    rst = 1'b0;
    wait_idle("t4_idle", 200);
    check("t4_bytesSent", 32'(bytesSent), 32'h1);

    // bytesSent wrap at COUNT_W=4
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      push(8'(k * 7 + 3));
      wait_idle("t5_idle", 100);
      if (k == 15) check("t5_count15", 32'(bytesSent), 32'd15);
      if (k == 16) check("t5_count16", 32'(bytesSent), 32'd0);
      if (k == 17) check("t5_count17", 32'(bytesSent), 32'd1);
    end

    // Two stop bits, byte 0xFF
    step();
    fifoEmpty2 = 1'b0;
    @(negedge clk);
    check("t6_readEn2", 32'(readEn2), 32'h1);
    step();
    fifoEmpty2 = 1'b1;
    @(negedge clk);
    check("t6_load_line", 32'(txData2), 32'h1);
    @(negedge clk);
    check("t6_start_low", 32'(txData2), 32'h0);
    bad = 0;
    for (int j = 1; j < 44; j++) begin
      @(negedge clk);
      if (j < 4 && txData2 !== 1'b0) bad |= 1;
      if (j >= 4 && txData2 !== 1'b1) bad |= 2;
    end
    check("t6_line_shape", 32'(bad), 32'h0);
    check("t6_busy_43", 32'(busy2), 32'h1);
    @(negedge clk);
    check("t6_busy_44", 32'(busy2), 32'h0);
    check("t6_bytesSent2", 32'(bytesSent2), 32'h1);

    repeat (5) step();
    check("all_frames_seen", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
